// File: rtl/pe_token_fifo.sv
// pe_token_fifo: elastic token buffer for a PE-to-PE link.
// Tokens are {vbl, flag, data}. Only tokens with a non-zero vbl are stored.
// The head token falls through to out_tok, and out_tok is zero while the buffer is empty.
// in_bp is registered from the next-state occupancy, so a pop at a full edge
// reopens the slot for the following cycle.
module pe_token_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned TOK_W  = TAG_W + 1 + DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [TOK_W-1:0]       in_tok,
  output logic                   in_bp,
  output logic [TOK_W-1:0]       out_tok,
  input  logic                   out_bp,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow_err,
  output logic [CNT_W-1:0]       tok_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [TOK_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             in_bp_q, in_bp_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             tok_valid;
  logic             push;
  logic             pop;
  logic [TOK_W-1:0] head;

  assign tok_valid = (in_tok[TOK_W-1 -: TAG_W] != '0);
  assign push      = tok_valid && in_bp_q && !flush;
  assign pop       = (occ_q != '0) && out_bp && !flush;
  assign head      = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy, backpressure, error and statistics
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    in_bp_d  = in_bp_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      in_bp_d  = 1'b1;
      err_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
      in_bp_d = (occ_d < OCC_W'(DEPTH));
      if (tok_valid && !in_bp_q) err_d = 1'b1;
      if (pop && !head[DATA_W]) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Control state register; reset discards stored tokens by clearing occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      in_bp_q  <= 1'b1;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      in_bp_q  <= in_bp_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Token storage; contents are meaningless while occupancy says empty, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_tok;
  end

  assign out_tok      = (occ_q != '0) ? head : '0;
  assign in_bp        = in_bp_q;
  assign occupancy    = occ_q;
  assign overflow_err = err_q;
  assign tok_count    = cnt_q;

endmodule

// File: tb/tb_pe_token_fifo.sv
// Directed bench for pe_token_fifo with DEPTH=4 and a 36-bit token.
module tb_pe_token_fifo;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 3;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TOK_W  = TAG_W + 1 + DATA_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic [TOK_W-1:0] in_tok = '0;
  logic             in_bp;
  logic [TOK_W-1:0] out_tok;
  logic             out_bp = 1'b0;
  logic [2:0]       occupancy;
  logic             overflow_err;
  logic [CNT_W-1:0] tok_count;

  int checks = 0;
  int errors = 0;

  pe_token_fifo #(
    .DATA_W(DATA_W),
    .TAG_W (TAG_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_tok      (in_tok),
    .in_bp       (in_bp),
    .out_tok     (out_tok),
    .out_bp      (out_bp),
    .occupancy   (occupancy),
    .overflow_err(overflow_err),
    .tok_count   (tok_count)
  );

  always #5 clk = ~clk;

  function automatic logic [TOK_W-1:0] mk(input logic [2:0] v, input logic f, input logic [31:0] d);
    return {v, f, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    checks++; if (in_bp !== 1'b1) begin errors++; $display("FAIL reset_in_bp: got %b expected 1", in_bp); end
    checks++; if (out_tok !== '0) begin errors++; $display("FAIL reset_out_tok: got %h expected 0", out_tok); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", overflow_err); end
    checks++; if (tok_count !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", tok_count); end
  endtask

  task automatic test_single();
    out_bp = 1'b1;
    in_tok = mk(3'b110, 1'b0, 32'd5);
    tick();
    in_tok = '0;
    checks++; if (out_tok !== mk(3'b110, 1'b0, 32'd5)) begin errors++; $display("FAIL single_visible: got %h expected %h", out_tok, mk(3'b110, 1'b0, 32'd5)); end
    checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL single_occ: got %0d expected 1", occupancy); end
    tick();
    checks++; if (out_tok !== '0) begin errors++; $display("FAIL single_gone: got %h expected 0", out_tok); end
    checks++; if (tok_count !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", tok_count); end
  endtask

  task automatic test_fill_overflow();
    out_bp = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_tok = mk(3'b001, 1'b0, 32'(i));
      tick();
    end
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL fill_occ: got %0d expected 4", occupancy); end
    checks++; if (in_bp !== 1'b0) begin errors++; $display("FAIL fill_in_bp: got %b expected 0", in_bp); end
    in_tok = mk(3'b001, 1'b0, 32'd5);
    tick();
    in_tok = '0;
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", overflow_err); end
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL ovf_occ: got %0d expected 4", occupancy); end
    out_bp = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (out_tok !== mk(3'b001, 1'b0, 32'(i))) begin errors++; $display("FAIL drain_order: got %h expected %h", out_tok, mk(3'b001, 1'b0, 32'(i))); end
      tick();
      if (i == 1) begin
        checks++; if (in_bp !== 1'b1) begin errors++; $display("FAIL drain_in_bp: got %b expected 1", in_bp); end
      end
    end
    checks++; if (out_tok !== '0) begin errors++; $display("FAIL drain_empty: got %h expected 0", out_tok); end
    checks++; if (tok_count !== 16'd5) begin errors++; $display("FAIL drain_cnt: got %0d expected 5", tok_count); end
  endtask

  task automatic test_back_to_back();
    int exp_v;
    int nxt;
    logic sent;
    out_bp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_tok = mk(3'b010, 1'b0, 32'(10 + i));
      tick();
    end
    in_tok = '0;
    checks++; if (in_bp !== 1'b0) begin errors++; $display("FAIL b2b_full_bp: got %b expected 0", in_bp); end
    out_bp = 1'b1;
    exp_v = 10;
    nxt = 14;
    for (int c = 0; c < 8; c++) begin
      checks++; if (out_tok !== mk(3'b010, 1'b0, 32'(exp_v))) begin errors++; $display("FAIL b2b_order: got %h expected %h", out_tok, mk(3'b010, 1'b0, 32'(exp_v))); end
      sent = in_bp;
      in_tok = sent ? mk(3'b010, 1'b0, 32'(nxt)) : '0;
      tick();
      exp_v++;
      if (sent) nxt++;
      if (c == 0) begin
        checks++; if (in_bp !== 1'b1) begin errors++; $display("FAIL b2b_reassert: got %b expected 1", in_bp); end
      end
      checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL b2b_occ: got %0d expected 3", occupancy); end
    end
    in_tok = '0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_tok !== mk(3'b010, 1'b0, 32'(exp_v))) begin errors++; $display("FAIL b2b_tail: got %h expected %h", out_tok, mk(3'b010, 1'b0, 32'(exp_v))); end
      tick();
      exp_v++;
    end
    checks++; if (exp_v !== 21 || nxt !== 21) begin errors++; $display("FAIL b2b_count: got %0d/%0d expected 21/21", exp_v, nxt); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL b2b_drained: got %0d expected 0", occupancy); end
    checks++; if (tok_count !== 16'd16) begin errors++; $display("FAIL b2b_cnt: got %0d expected 16", tok_count); end
  endtask

  task automatic test_flag();
    out_bp = 1'b1;
    in_tok = mk(3'b100, 1'b1, 32'd9);
    tick();
    checks++; if (out_tok !== mk(3'b100, 1'b1, 32'd9)) begin errors++; $display("FAIL flag_first: got %h expected %h", out_tok, mk(3'b100, 1'b1, 32'd9)); end
    in_tok = mk(3'b001, 1'b0, 32'd7);
    tick();
    in_tok = '0;
    checks++; if (out_tok !== mk(3'b001, 1'b0, 32'd7)) begin errors++; $display("FAIL flag_second: got %h expected %h", out_tok, mk(3'b001, 1'b0, 32'd7)); end
    checks++; if (tok_count !== 16'd16) begin errors++; $display("FAIL flag_not_counted: got %0d expected 16", tok_count); end
    tick();
    checks++; if (tok_count !== 16'd17) begin errors++; $display("FAIL flag_cnt: got %0d expected 17", tok_count); end
    in_tok = mk(3'b000, 1'b1, 32'hFFFF_FFFF);
    tick();
    in_tok = '0;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL invalid_stored: got %0d expected 0", occupancy); end
  endtask

  task automatic test_reset_flush();
    out_bp = 1'b0;
    in_tok = mk(3'b001, 1'b0, 32'd40);
    tick();
    in_tok = mk(3'b001, 1'b0, 32'd41);
    tick();
    in_tok = '0;
    checks++; if (occupancy !== 3'd2 || overflow_err !== 1'b1) begin errors++; $display("FAIL pre_reset: got occ %0d err %b expected 2 1", occupancy, overflow_err); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_tok !== '0 || in_bp !== 1'b1 || occupancy !== 3'd0 || overflow_err !== 1'b0 || tok_count !== 16'd0) begin
      errors++; $display("FAIL async_reset: got tok %h bp %b occ %0d err %b cnt %0d expected 0 1 0 0 0", out_tok, in_bp, occupancy, overflow_err, tok_count);
    end
    #1 reset = 1'b0;
    out_bp = 1'b1;
    in_tok = mk(3'b011, 1'b0, 32'd50);
    tick();
    in_tok = '0;
    tick();
    out_bp = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_tok = mk(3'b001, 1'b0, 32'(60 + i));
      tick();
    end
    in_tok = '0;
    out_bp = 1'b1;
    tick();
    tick();
    out_bp = 1'b0;
    checks++; if (occupancy !== 3'd2 || overflow_err !== 1'b1 || tok_count !== 16'd3) begin
      errors++; $display("FAIL pre_flush: got occ %0d err %b cnt %0d expected 2 1 3", occupancy, overflow_err, tok_count);
    end
    flush = 1'b1;
    in_tok = mk(3'b111, 1'b0, 32'd99);
    tick();
    flush = 1'b0;
    in_tok = '0;
    checks++; if (occupancy !== 3'd0 || overflow_err !== 1'b0 || in_bp !== 1'b1 || out_tok !== '0) begin
      errors++; $display("FAIL flush_state: got occ %0d err %b bp %b tok %h expected 0 0 1 0", occupancy, overflow_err, in_bp, out_tok);
    end
    checks++; if (tok_count !== 16'd3) begin errors++; $display("FAIL flush_cnt_kept: got %0d expected 3", tok_count); end
    tick();
    checks++; if (occupancy !== 3'd0 || overflow_err !== 1'b0) begin errors++; $display("FAIL flush_drop: got occ %0d err %b expected 0 0", occupancy, overflow_err); end
  endtask

  initial begin
    test_reset();
    tick();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_flag();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
